// File: rtl/data_mem_pkg.sv
// Shared definitions for the byte-addressed data memory / load-store unit.
package data_mem_pkg;

    // RV32 load/store width codes carried in funct3
    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic {CLEAR, READY} state_t;

    // Ceiling log2, constant-evaluable; clog2(1) = 0
    function automatic int unsigned clog2(input int unsigned value);
        int unsigned res;
        res = 0;
        for (int i = 0; i < 32; i++) begin
            if ((64'd1 << i) < 64'(value)) res = i + 1;
        end
        return res;
    endfunction

endpackage

// File: rtl/data_mem_align.sv
// Combinational lane logic: store byte-enables and data replication, load
// lane extraction with sign/zero extension, and misaligned/illegal detection.
module data_mem_align
    import data_mem_pkg::*;
(
    input  logic        we,
    input  logic [1:0]  lane,
    input  logic [2:0]  funct3,
    input  logic [31:0] wdata,
    input  logic [31:0] rword,
    output logic [3:0]  be,
    output logic [31:0] wdata_lanes,
    output logic [31:0] load_data,
    output logic        bad
);

    logic [7:0]  byte_v;
    logic [15:0] half_v;

    assign byte_v = rword[{lane, 3'b000} +: 8];
    assign half_v = rword[{lane[1], 4'b0000} +: 16];

    // Decode width code into lane controls; anything not listed is illegal
    always_comb begin
        be          = 4'b0000;
        wdata_lanes = 32'd0;
        load_data   = 32'd0;
        bad         = 1'b0;
        if (we) begin
            case (funct3)
                F3_B: begin
                    be          = 4'b0001 << lane;
                    wdata_lanes = {4{wdata[7:0]}};
                end
                F3_H: begin
                    be          = lane[1] ? 4'b1100 : 4'b0011;
                    wdata_lanes = {2{wdata[15:0]}};
                    bad         = lane[0];
                end
                F3_W: begin
                    be          = 4'b1111;
                    wdata_lanes = wdata;
                    bad         = |lane;
                end
                default: bad = 1'b1;
            endcase
        end else begin
            case (funct3)
                F3_B:  load_data = {{24{byte_v[7]}}, byte_v};
                F3_BU: load_data = {24'd0, byte_v};
                F3_H: begin
                    load_data = {{16{half_v[15]}}, half_v};
                    bad       = lane[0];
                end
                F3_HU: begin
                    load_data = {16'd0, half_v};
                    bad       = lane[0];
                end
                F3_W: begin
                    load_data = rword;
                    bad       = |lane;
                end
                default: bad = 1'b1;
            endcase
        end
    end

endmodule

// File: rtl/data_mem_lsu.sv
// Byte-addressed little-endian data memory with RV32 load/store semantics,
// valid/ready request, one-cycle registered response and a post-reset clear.
module data_mem_lsu
    import data_mem_pkg::*;
#(
    parameter int unsigned DEPTH_BYTES = 256,
    parameter int unsigned ADDR_W      = 32,
    parameter int unsigned XLEN        = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [2:0]        req_funct3,
    input  logic [XLEN-1:0]   req_wdata,
    output logic              rsp_valid,
    output logic [XLEN-1:0]   rsp_rdata,
    output logic              rsp_err
);

    localparam int unsigned WORDS = DEPTH_BYTES / 4;
    localparam int unsigned IDX_W = (WORDS > 1) ? clog2(WORDS) : 1;

    state_t           state_q, state_d;
    logic [IDX_W-1:0] clr_idx_q, clr_idx_d;
    logic             clr_we;

    logic [31:0]      mem [WORDS];
    logic [IDX_W-1:0] word_idx;
    logic [31:0]      rd_word;

    logic             accept;
    logic             out_of_range;
    logic             code_err;
    logic             err;
    logic             st_we;
    logic [3:0]       store_be;
    logic [31:0]      store_data;
    logic [31:0]      load_data;

    logic             rsp_valid_q;
    logic [XLEN-1:0]  rsp_rdata_q;
    logic             rsp_err_q;

    assign req_ready    = (state_q == READY);
    assign accept       = req_valid && req_ready;
    assign word_idx     = IDX_W'(req_addr >> 2);
    assign rd_word      = mem[word_idx];
    assign out_of_range = (req_addr >= ADDR_W'(DEPTH_BYTES));
    assign err          = out_of_range || code_err;
    assign st_we        = accept && req_we && !err;

    data_mem_align u_align (
        .we          (req_we),
        .lane        (req_addr[1:0]),
        .funct3      (req_funct3),
        .wdata       (req_wdata[31:0]),
        .rword       (rd_word),
        .be          (store_be),
        .wdata_lanes (store_data),
        .load_data   (load_data),
        .bad         (code_err)
    );

    // Clear sweep walks every word once, then the block stays READY
    always_comb begin
        state_d   = state_q;
        clr_idx_d = clr_idx_q;
        clr_we    = 1'b0;
        case (state_q)
            CLEAR: begin
                clr_we    = 1'b1;
                clr_idx_d = clr_idx_q + 1'b1;
                if (clr_idx_q == IDX_W'(WORDS - 1)) begin
                    state_d   = READY;
                    clr_idx_d = '0;
                end
            end
            READY:   state_d = READY;
            default: state_d = CLEAR;
        endcase
    end

    // State and sweep counter; reset restarts the sweep from word 0
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q   <= CLEAR;
            clr_idx_q <= '0;
        end else begin
            state_q   <= state_d;
            clr_idx_q <= clr_idx_d;
        end
    end

    // Storage writes: clear sweep or byte-lane store; nothing while in reset
    always_ff @(posedge clk) begin
        if (rst) begin
            if (clr_we) begin
                mem[clr_idx_q] <= 32'd0;
            end else if (st_we) begin
                for (int i = 0; i < 4; i++) begin
                    if (store_be[i]) mem[word_idx][i*8 +: 8] <= store_data[i*8 +: 8];
                end
            end
        end
    end

    // Registered response: one-cycle pulse per accept, data zeroed otherwise
    always_ff @(posedge clk) begin
        if (!rst) begin
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
            rsp_err_q   <= 1'b0;
        end else begin
            rsp_valid_q <= accept;
            rsp_err_q   <= accept && err;
            rsp_rdata_q <= (accept && !req_we && !err) ? XLEN'(load_data) : '0;
        end
    end

    assign rsp_valid = rsp_valid_q;
    assign rsp_rdata = rsp_rdata_q;
    assign rsp_err   = rsp_err_q;

endmodule

// File: tb/tb_data_mem_lsu.sv
// Scoreboard bench for data_mem_lsu: the driver queues the expected response
// and arrival cycle, the monitor checks whatever the DUT returns.
module tb_data_mem_lsu;

    logic        clk;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [31:0] req_addr;
    logic [2:0]  req_funct3;
    logic [31:0] req_wdata;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_err;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    logic [32:0] exp_q [$];
    int          cyc_q [$];
    string       name_q [$];

    data_mem_lsu #(
        .DEPTH_BYTES (256),
        .ADDR_W      (32),
        .XLEN        (32)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_we     (req_we),
        .req_addr   (req_addr),
        .req_funct3 (req_funct3),
        .req_wdata  (req_wdata),
        .rsp_valid  (rsp_valid),
        .rsp_rdata  (rsp_rdata),
        .rsp_err    (rsp_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string nm, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, got, exp);
        end
    endtask

    // Monitor: pop and compare on every response; idle cycles must be zero
    initial begin
        forever begin
            @(negedge clk);
            if (rsp_valid === 1'b1) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_rsp: got rdata %h err %b expected no response",
                             rsp_rdata, rsp_err);
                end else begin
                    logic [32:0] e;
                    int          ec;
                    string       nm;
                    e  = exp_q.pop_front();
                    ec = cyc_q.pop_front();
                    nm = name_q.pop_front();
                    check({nm, "_rdata"}, rsp_rdata, e[31:0]);
                    check({nm, "_err"}, {31'd0, rsp_err}, {31'd0, e[32]});
                    check({nm, "_latency"}, 32'(cyc), 32'(ec));
                end
            end else if (rst === 1'b1) begin
                check("idle_zero", {rsp_rdata[30:0], rsp_err}, 32'd0);
            end
        end
    end

    task automatic issue(input string nm, input logic we, input logic [2:0] f3,
                         input logic [31:0] addr, input logic [31:0] wd,
                         input logic [31:0] exp_rd, input logic exp_err);
        @(negedge clk);
        if (req_ready !== 1'b1) begin
            checks++;
            errors++;
            $display("FAIL %s_ready: got %b expected 1", nm, req_ready);
            req_valid = 1'b0;
            return;
        end
        req_valid  = 1'b1;
        req_we     = we;
        req_funct3 = f3;
        req_addr   = addr;
        req_wdata  = wd;
        exp_q.push_back({exp_err, exp_rd});
        cyc_q.push_back(cyc + 1);
        name_q.push_back(nm);
        @(posedge clk);
    endtask

    // Count negedges with req_ready low from the release point, bounded
    task automatic wait_clear(input string nm);
        int n;
        n = 0;
        while (req_ready !== 1'b1 && n < 200) begin
            n++;
            @(negedge clk);
        end
        check(nm, 32'(n), 32'd64);
    endtask

    initial begin
        rst        = 1'b0;
        req_valid  = 1'b0;
        req_we     = 1'b0;
        req_addr   = 32'd0;
        req_funct3 = 3'd0;
        req_wdata  = 32'd0;

        @(negedge clk);
        check("reset_ready", {31'd0, req_ready}, 32'd0);
        check("reset_valid", {31'd0, rsp_valid}, 32'd0);
        @(negedge clk);
        rst = 1'b1;
        wait_clear("clear_cycles");

        // Cleared memory
        issue("lw32",  1'b0, 3'b010, 32'd32,  32'd0, 32'd0, 1'b0);
        issue("lw124", 1'b0, 3'b010, 32'd124, 32'd0, 32'd0, 1'b0);
        issue("lw252", 1'b0, 3'b010, 32'd252, 32'd0, 32'd0, 1'b0);

        // Word round trip
        issue("sw88",  1'b1, 3'b010, 32'd88, 32'd66, 32'd0,  1'b0);
        issue("lw88",  1'b0, 3'b010, 32'd88, 32'd0,  32'd66, 1'b0);
        issue("lw92",  1'b0, 3'b010, 32'd92, 32'd0,  32'd0,  1'b0);

        // Byte sign handling
        issue("sb51",  1'b1, 3'b000, 32'd51, 32'hFFFFFF9E, 32'd0, 1'b0);
        issue("lb51",  1'b0, 3'b000, 32'd51, 32'd0, 32'hFFFFFF9E, 1'b0);
        issue("lbu51", 1'b0, 3'b100, 32'd51, 32'd0, 32'h0000009E, 1'b0);
        issue("lw48",  1'b0, 3'b010, 32'd48, 32'd0, 32'h9E000000, 1'b0);

        // Half lanes
        issue("sh90",    1'b1, 3'b001, 32'd90, 32'h00008001, 32'd0, 1'b0);
        issue("lh90",    1'b0, 3'b001, 32'd90, 32'd0, 32'hFFFF8001, 1'b0);
        issue("lhu90",   1'b0, 3'b101, 32'd90, 32'd0, 32'h00008001, 1'b0);
        issue("sw92",    1'b1, 3'b010, 32'd92, 32'h12345678, 32'd0, 1'b0);
        issue("lhu90b",  1'b0, 3'b101, 32'd90, 32'd0, 32'h00008001, 1'b0);
        issue("lw88mix", 1'b0, 3'b010, 32'd88, 32'd0, 32'h80010042, 1'b0);

        // Errors and rereads
        issue("sw90_mis",   1'b1, 3'b010, 32'd90,  32'hDEADBEEF, 32'd0, 1'b1);
        issue("lw88_after", 1'b0, 3'b010, 32'd88,  32'd0, 32'h80010042, 1'b0);
        issue("lh51_mis",   1'b0, 3'b001, 32'd51,  32'd0, 32'd0, 1'b1);
        issue("lw256_oor",  1'b0, 3'b010, 32'd256, 32'd0, 32'd0, 1'b1);
        issue("st_f3_3",    1'b1, 3'b011, 32'd92,  32'hFFFFFFFF, 32'd0, 1'b1);
        issue("lw92_after", 1'b0, 3'b010, 32'd92,  32'd0, 32'h12345678, 1'b0);
        issue("ld_f3_6",    1'b0, 3'b110, 32'd0,   32'd0, 32'd0, 1'b1);
        issue("sb255",      1'b1, 3'b000, 32'd255, 32'h000000A5, 32'd0, 1'b0);
        issue("lbu255",     1'b0, 3'b100, 32'd255, 32'd0, 32'h000000A5, 1'b0);

        // Reset mid-operation
        issue("lw88_prerst", 1'b0, 3'b010, 32'd88, 32'd0, 32'h80010042, 1'b0);
        @(negedge clk);
        req_valid = 1'b0;
        rst       = 1'b0;
        @(negedge clk);
        check("rst_mid_valid", {31'd0, rsp_valid}, 32'd0);
        check("rst_mid_ready", {31'd0, req_ready}, 32'd0);
        rst = 1'b1;
        wait_clear("reclear_cycles");
        issue("lw88_clr", 1'b0, 3'b010, 32'd88, 32'd0, 32'd0, 1'b0);
        issue("lw92_clr", 1'b0, 3'b010, 32'd92, 32'd0, 32'd0, 1'b0);
        issue("lw48_clr", 1'b0, 3'b010, 32'd48, 32'd0, 32'd0, 1'b0);

        @(negedge clk);
        req_valid = 1'b0;
        repeat (4) @(negedge clk);
        check("drain", 32'(exp_q.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
